// File: rtl/rio_tx.sv
// rio_tx: serial output stage for the I/O register of the 8-bit core.
//
// The block watches the register-file write port. Every write to register IO_REG is pushed
// into a small circular FIFO. Queued bytes leave on `tx` as UART 8N1 frames, LSB first.
// When bytes are waiting, frames go out back to back with no idle gap between them.
//
// Parameters:
//   CLKS_PER_BIT - clock cycles per serial bit (>= 2)
//   DEPTH        - FIFO entries (power of two, >= 2)
//   IO_REG       - register index treated as the I/O port
//
// Ports:
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   write_enable in   register-file write strobe
//   dst[2:0]     in   register-file write destination
//   wr_data[7:0] in   register-file write data
//   clr_overflow in   synchronous clear of overflow (a drop in the same cycle wins)
//   tx           out  serial line, idle high, driven from a flop
//   busy         out  frame in flight or FIFO non-empty
//   full         out  FIFO holds DEPTH entries
//   overflow     out  sticky, a push was dropped
module rio_tx #(
   parameter int unsigned CLKS_PER_BIT = 16,
   parameter int unsigned DEPTH        = 4,
   parameter int unsigned IO_REG       = 7
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       write_enable,
   input  logic [2:0] dst,
   input  logic [7:0] wr_data,
   input  logic       clr_overflow,
   output logic       tx,
   output logic       busy,
   output logic       full,
   output logic       overflow
);

   localparam int unsigned BaudW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int unsigned PtrW  = $clog2(DEPTH);
   localparam int unsigned CntW  = $clog2(DEPTH + 1);

   localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);
   localparam logic [CntW-1:0]  CntFull  = CntW'(DEPTH);
   localparam logic [2:0]       IoReg    = 3'(IO_REG);

   typedef enum logic [1:0] {
      StIdle,
      StStart,
      StData,
      StStop
   } state_e;

   state_e            state_q, state_d;
   logic [BaudW-1:0]  baud_q, baud_d;
   logic [2:0]        bit_q, bit_d;
   logic [7:0]        shift_q, shift_d;
   logic              tx_q, tx_d;
   logic [7:0]        mem_q [DEPTH];
   logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [CntW-1:0]   count_q, count_d;
   logic              overflow_q, overflow_d;

   logic push_req, push, pop, drop;
   logic baud_end, fifo_empty, fifo_full;

   assign fifo_empty = (count_q == '0);
   assign fifo_full  = (count_q == CntFull);
   assign baud_end   = (baud_q == BaudLast);

   // A push into a full FIFO is still accepted when the FSM pops in the same cycle.
   assign push_req = write_enable && (dst == IoReg);
   assign push     = push_req && (!fifo_full || pop);
   assign drop     = push_req && !push;

   // ---------------------------------------------------------------- transmit FSM
   always_comb begin
      state_d = state_q;
      baud_d  = baud_q + BaudW'(1);
      bit_d   = bit_q;
      shift_d = shift_q;
      pop     = 1'b0;
      unique case (state_q)
         StIdle: begin
            baud_d = '0;
            if (!fifo_empty) begin
               pop     = 1'b1;
               shift_d = mem_q[rd_ptr_q];
               state_d = StStart;
            end
         end
         StStart: begin
            if (baud_end) begin
               baud_d  = '0;
               bit_d   = '0;
               state_d = StData;
            end
         end
         StData: begin
            if (baud_end) begin
               baud_d  = '0;
               shift_d = {1'b0, shift_q[7:1]};
               if (bit_q == 3'd7) begin
                  state_d = StStop;
               end else begin
                  bit_d = bit_q + 3'd1;
               end
            end
         end
         StStop: begin
            if (baud_end) begin
               baud_d = '0;
               // Chain straight into the next start bit when more data is queued.
               if (!fifo_empty) begin
                  pop     = 1'b1;
                  shift_d = mem_q[rd_ptr_q];
                  state_d = StStart;
               end else begin
                  state_d = StIdle;
               end
            end
         end
         default: begin
            baud_d  = '0;
            state_d = StIdle;
         end
      endcase
   end

   // Line level is computed from the next state so tx changes on the same edge as the state.
   always_comb begin
      tx_d = 1'b1;
      unique case (state_d)
         StStart: tx_d = 1'b0;
         StData:  tx_d = shift_d[0];
         default: tx_d = 1'b1;
      endcase
   end

   // ---------------------------------------------------------------- FIFO bookkeeping
   always_comb begin
      count_d = count_q;
      unique case ({push, pop})
         2'b10:   count_d = count_q + CntW'(1);
         2'b01:   count_d = count_q - CntW'(1);
         default: count_d = count_q;
      endcase
   end

   always_comb begin
      overflow_d = overflow_q;
      if (drop) begin
         overflow_d = 1'b1;
      end else if (clr_overflow) begin
         overflow_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         baud_q     <= '0;
         bit_q      <= '0;
         shift_q    <= '0;
         tx_q       <= 1'b1;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         baud_q     <= baud_d;
         bit_q      <= bit_d;
         shift_q    <= shift_d;
         tx_q       <= tx_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         if (push) begin
            wr_ptr_q <= wr_ptr_q + PtrW'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PtrW'(1);
         end
      end
   end

   // Storage needs no reset: entries are only read after being written.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= wr_data;
      end
   end

   assign tx       = tx_q;
   assign busy     = (state_q != StIdle) || !fifo_empty;
   assign full     = fifo_full;
   assign overflow = overflow_q;

endmodule

// File: tb/tb_rio_tx.sv
// Directed testbench for rio_tx with CLKS_PER_BIT=4 and DEPTH=4.
// A background UART decoder collects frames seen on tx. Each test task compares results inline.
module tb_rio_tx;

   localparam int CPB = 4;
   localparam int DEP = 4;

   logic       clk          = 1'b0;
   logic       rst_n        = 1'b0;
   logic       write_enable = 1'b0;
   logic [2:0] dst          = 3'd0;
   logic [7:0] wr_data      = 8'h00;
   logic       clr_overflow = 1'b0;
   logic       tx, busy, full, overflow;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   byte unsigned rx_data[$];
   int           rx_start[$];
   bit           rx_frm[$];

   rio_tx #(
      .CLKS_PER_BIT(CPB),
      .DEPTH       (DEP),
      .IO_REG      (7)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .write_enable(write_enable),
      .dst         (dst),
      .wr_data     (wr_data),
      .clr_overflow(clr_overflow),
      .tx          (tx),
      .busy        (busy),
      .full        (full),
      .overflow    (overflow)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // UART decoder: samples mid-bit, drops any frame that sees reset.
   logic [7:0] mon_d;
   bit         mon_so, mon_sp, mon_ab;
   int         mon_st;
   initial begin
      forever begin
         @(posedge clk);
         #2;
         if (rst_n && tx == 1'b0) begin
            mon_st = cyc;
            mon_ab = 1'b0;
            mon_so = 1'b0;
            mon_sp = 1'b0;
            mon_d  = 8'h00;
            for (int i = 1; i < 10 * CPB && !mon_ab; i++) begin
               @(posedge clk);
               #2;
               if (!rst_n) begin
                  mon_ab = 1'b1;
               end else if (i % CPB == CPB / 2) begin
                  if (i / CPB == 0) mon_so = !tx;
                  else if (i / CPB <= 8) mon_d[i/CPB-1] = tx;
                  else mon_sp = tx;
               end
            end
            if (!mon_ab) begin
               rx_data.push_back(mon_d);
               rx_start.push_back(mon_st);
               rx_frm.push_back(mon_so && mon_sp);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      write_enable = 1'b0;
      clr_overflow = 1'b0;
      rst_n        = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      rx_data.delete();
      rx_start.delete();
      rx_frm.delete();
   endtask

   task automatic test_reset();
      #12;
      total++;
      if (tx !== 1'b1 || busy !== 1'b0 || full !== 1'b0 || overflow !== 1'b0) begin
         bad++;
         $display("FAIL reset_held: tx=%b busy=%b full=%b ovf=%b want 1 0 0 0",
                  tx, busy, full, overflow);
      end
      apply_reset();
      tick();
      total++;
      if (tx !== 1'b1 || busy !== 1'b0 || full !== 1'b0 || overflow !== 1'b0) begin
         bad++;
         $display("FAIL reset_release: tx=%b busy=%b full=%b ovf=%b want 1 0 0 0",
                  tx, busy, full, overflow);
      end
   endtask

   task automatic test_single_byte();
      logic [9:0] frame;
      logic       exp_tx;
      apply_reset();
      frame = {1'b1, 8'hA5, 1'b0};
      dst = 3'd7; wr_data = 8'hA5; write_enable = 1'b1;
      tick();
      write_enable = 1'b0;
      total++;
      if (tx !== 1'b1 || busy !== 1'b1) begin
         bad++;
         $display("FAIL sb_after_push: tx=%b busy=%b want 1 1", tx, busy);
      end
      tick();
      for (int i = 0; i < 10 * CPB; i++) begin
         exp_tx = frame[i/CPB];
         total++;
         if (tx !== exp_tx || busy !== 1'b1) begin
            bad++;
            $display("FAIL sb_cycle%0d: tx=%b busy=%b want %b 1", i, tx, busy, exp_tx);
         end
         tick();
      end
      total++;
      if (tx !== 1'b1 || busy !== 1'b0) begin
         bad++;
         $display("FAIL sb_end: tx=%b busy=%b want 1 0", tx, busy);
      end
      total++;
      if (rx_data.size() != 1 || rx_data[0] != 8'hA5) begin
         bad++;
         $display("FAIL sb_decode: frames=%0d want 1 byte A5", rx_data.size());
      end
   endtask

   task automatic test_filter();
      apply_reset();
      for (int r = 0; r < 7; r++) begin
         dst = 3'(r); wr_data = 8'hFF; write_enable = 1'b1;
         tick();
      end
      write_enable = 1'b0;
      for (int i = 0; i < 3 * CPB; i++) begin
         total++;
         if (tx !== 1'b1 || busy !== 1'b0 || full !== 1'b0 || overflow !== 1'b0) begin
            bad++;
            $display("FAIL filter_cycle%0d: tx=%b busy=%b full=%b ovf=%b want 1 0 0 0",
                     i, tx, busy, full, overflow);
         end
         tick();
      end
      total++;
      if (rx_data.size() != 0) begin
         bad++;
         $display("FAIL filter_frames: got %0d want 0", rx_data.size());
      end
   endtask

   task automatic test_overflow();
      int waited;
      apply_reset();
      for (int k = 1; k <= 6; k++) begin
         dst = 3'd7; wr_data = 8'(k); write_enable = 1'b1;
         tick();
         if (k == 4) begin
            total++;
            if (full !== 1'b0) begin
               bad++;
               $display("FAIL ovf_full_early: full=%b want 0", full);
            end
         end
         if (k == 5) begin
            total++;
            if (full !== 1'b1 || overflow !== 1'b0) begin
               bad++;
               $display("FAIL ovf_full: full=%b ovf=%b want 1 0", full, overflow);
            end
         end
      end
      write_enable = 1'b0;
      total++;
      if (overflow !== 1'b1 || full !== 1'b1) begin
         bad++;
         $display("FAIL ovf_drop: ovf=%b full=%b want 1 1", overflow, full);
      end
      waited = 0;
      while (busy === 1'b1 && waited < 60 * CPB) begin
         tick();
         waited++;
      end
      total++;
      if (busy !== 1'b0 || rx_start.size() == 0 || cyc - rx_start[0] != 50 * CPB) begin
         bad++;
         $display("FAIL ovf_total_len: busy=%b frames=%0d cycles=%0d want 0 5 %0d", busy,
                  rx_start.size(), (rx_start.size() > 0) ? cyc - rx_start[0] : -1, 50 * CPB);
      end
      total++;
      if (rx_data.size() != 5) begin
         bad++;
         $display("FAIL ovf_count: got %0d frames want 5", rx_data.size());
      end else begin
         for (int k = 0; k < 5; k++) begin
            total++;
            if (rx_data[k] != 8'(k + 1) || !rx_frm[k]) begin
               bad++;
               $display("FAIL ovf_byte%0d: got %02h framing=%0b want %02h 1",
                        k, rx_data[k], rx_frm[k], k + 1);
            end
            if (k > 0) begin
               total++;
               if (rx_start[k] - rx_start[k-1] != 10 * CPB) begin
                  bad++;
                  $display("FAIL ovf_gap%0d: got %0d want %0d",
                           k, rx_start[k] - rx_start[k-1], 10 * CPB);
               end
            end
         end
      end
   endtask

   task automatic test_sticky_clear();
      apply_reset();
      for (int k = 0; k < 5; k++) begin
         dst = 3'd7; wr_data = 8'(8'h10 + k); write_enable = 1'b1;
         tick();
      end
      total++;
      if (full !== 1'b1 || overflow !== 1'b0) begin
         bad++;
         $display("FAIL sticky_pre: full=%b ovf=%b want 1 0", full, overflow);
      end
      wr_data = 8'h99; clr_overflow = 1'b1;
      tick();
      write_enable = 1'b0;
      total++;
      if (overflow !== 1'b1) begin
         bad++;
         $display("FAIL sticky_set_wins: ovf=%b want 1", overflow);
      end
      tick();
      clr_overflow = 1'b0;
      total++;
      if (overflow !== 1'b0) begin
         bad++;
         $display("FAIL sticky_clear: ovf=%b want 0", overflow);
      end
      tick();
      total++;
      if (overflow !== 1'b0 || full !== 1'b1) begin
         bad++;
         $display("FAIL sticky_hold: ovf=%b full=%b want 0 1", overflow, full);
      end
   endtask

   task automatic test_full_pop();
      int waited;
      apply_reset();
      for (int k = 1; k <= 5; k++) begin
         dst = 3'd7; wr_data = 8'(8'h11 * k); write_enable = 1'b1;
         tick();
      end
      write_enable = 1'b0;
      repeat (36) tick();
      total++;
      if (full !== 1'b1 || overflow !== 1'b0 || tx !== 1'b1) begin
         bad++;
         $display("FAIL fp_stop: full=%b ovf=%b tx=%b want 1 0 1", full, overflow, tx);
      end
      wr_data = 8'h66; write_enable = 1'b1;
      tick();
      write_enable = 1'b0;
      total++;
      if (full !== 1'b1 || overflow !== 1'b0 || tx !== 1'b0) begin
         bad++;
         $display("FAIL fp_accept: full=%b ovf=%b tx=%b want 1 0 0", full, overflow, tx);
      end
      waited = 0;
      while (busy === 1'b1 && waited < 70 * CPB) begin
         tick();
         waited++;
      end
      total++;
      if (rx_data.size() != 6) begin
         bad++;
         $display("FAIL fp_count: got %0d frames want 6", rx_data.size());
      end else begin
         for (int k = 0; k < 6; k++) begin
            total++;
            if (rx_data[k] != 8'(8'h11 * (k + 1)) || !rx_frm[k]) begin
               bad++;
               $display("FAIL fp_byte%0d: got %02h framing=%0b want %02h 1",
                        k, rx_data[k], rx_frm[k], 8'(8'h11 * (k + 1)));
            end
         end
         total++;
         if (rx_start[5] - rx_start[0] != 50 * CPB) begin
            bad++;
            $display("FAIL fp_contig: got %0d want %0d", rx_start[5] - rx_start[0], 50 * CPB);
         end
      end
   endtask

   task automatic test_reset_mid();
      int waited;
      apply_reset();
      dst = 3'd7; wr_data = 8'hF0; write_enable = 1'b1;
      tick();
      write_enable = 1'b0;
      repeat (18) tick();
      total++;
      if (tx !== 1'b0 || busy !== 1'b1) begin
         bad++;
         $display("FAIL rm_bit3: tx=%b busy=%b want 0 1", tx, busy);
      end
      rst_n = 1'b0;
      #1;
      total++;
      if (tx !== 1'b1 || busy !== 1'b0 || full !== 1'b0) begin
         bad++;
         $display("FAIL rm_async: tx=%b busy=%b full=%b want 1 0 0", tx, busy, full);
      end
      tick();
      tick();
      rst_n = 1'b1;
      rx_data.delete();
      rx_start.delete();
      rx_frm.delete();
      for (int i = 0; i < 12 * CPB; i++) begin
         total++;
         if (tx !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL rm_quiet%0d: tx=%b busy=%b want 1 0", i, tx, busy);
         end
         tick();
      end
      dst = 3'd7; wr_data = 8'h3C; write_enable = 1'b1;
      tick();
      write_enable = 1'b0;
      waited = 0;
      while (rx_data.size() == 0 && waited < 12 * CPB + 4) begin
         tick();
         waited++;
      end
      total++;
      if (rx_data.size() != 1 || rx_data[0] != 8'h3C || !rx_frm[0]) begin
         bad++;
         $display("FAIL rm_new_byte: frames=%0d byte=%02h want 1 3C",
                  rx_data.size(), (rx_data.size() > 0) ? rx_data[0] : 8'h00);
      end
   endtask

   initial begin
      test_reset();
      test_single_byte();
      test_filter();
      test_overflow();
      test_sticky_clear();
      test_full_pop();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
